// File: rtl/pic_cascade_pkg.sv
// Shared types and constants for the cascaded-PIC slave acknowledge responder.
package pic_cascade_pkg;

    // Acknowledge sequence states: first INTA pulse, inter-pulse gap, vector pulse
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK2 = 2'd3
    } cas_state_t;

    // Last GAP count value before the sequence is abandoned
    localparam logic [7:0] GAP_TIMEOUT    = 8'd255;
    // Level reported when the request vanished before the vector pulse
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Vector byte: ICW2 base bits T7..T3 followed by the in-service level
    function automatic logic [7:0] make_vector(input logic [4:0] base,
                                               input logic [2:0] level,
                                               input logic       pending);
        logic [2:0] lvl;
        if (pending) begin
            lvl = level;
        end else begin
            lvl = SPURIOUS_LEVEL;
        end
        return {base, lvl};
    endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// INTA_n edge detector with optional 2-flop input synchronizer.
// Build option: CAS_INPUT_SYNC_EN adds 2-flop synchronizers on INTA_n and CAS_IN,
// delaying every edge detection and cascade compare by two clocks.
module inta_edge_detect (
    input  logic       clk,
    input  logic       reset,
    input  logic       inta_n,
    input  logic [2:0] cas_in,
    output logic       inta_fall,
    output logic       inta_rise,
    output logic [2:0] cas_cmp
);

    logic inta_src_s;
    logic inta_q;

`ifdef CAS_INPUT_SYNC_EN
    logic       inta_sync1_r;
    logic       inta_sync2_r;
    logic [2:0] cas_sync1_r;
    logic [2:0] cas_sync2_r;

    // Two-stage synchronizer for the asynchronous acknowledge and cascade lines
    always_ff @(posedge clk) begin
        if (reset) begin
            inta_sync1_r <= 1'b1;
            inta_sync2_r <= 1'b1;
            cas_sync1_r  <= 3'd0;
            cas_sync2_r  <= 3'd0;
        end else begin
            inta_sync1_r <= inta_n;
            inta_sync2_r <= inta_sync1_r;
            cas_sync1_r  <= cas_in;
            cas_sync2_r  <= cas_sync1_r;
        end
    end

    assign inta_src_s = inta_sync2_r;
    assign cas_cmp    = cas_sync2_r;
`else
    assign inta_src_s = inta_n;
    assign cas_cmp    = cas_in;
`endif

    // Previous-cycle copy of INTA_n; resets high so a held-low line reads as a new edge
    always_ff @(posedge clk) begin
        if (reset) begin
            inta_q <= 1'b1;
        end else begin
            inta_q <= inta_src_s;
        end
    end

    assign inta_fall = inta_q & ~inta_src_s;
    assign inta_rise = ~inta_q & inta_src_s;

endmodule

// File: rtl/cascade_slave_responder.sv
// Slave-side cascade responder of an 8259-style PIC: follows the two INTA
// pulses, decides from CAS_IN whether this slave is addressed, and drives the
// vector byte during the second pulse. Optional build macro CAS_INPUT_SYNC_EN
// (see inta_edge_detect) adds two cycles of input synchronization latency.
module cascade_slave_responder
    import pic_cascade_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] CAS_IN,
    input  logic       SNGL,
    input  logic       Master_Slave,
    input  logic [2:0] Slave_ID,
    input  logic       INTA_n,
    input  logic [4:0] Vector_base,
    input  logic [2:0] IRQ_level,
    input  logic       Int_pending,
    output logic [7:0] Data_out,
    output logic       Data_oe,
    output logic       Selected,
    output logic       Inta_done,
    output logic       Ack_error
);

    cas_state_t state_r;
    logic [7:0] gap_cnt_r;
    logic       inta_fall_s;
    logic       inta_rise_s;
    logic [2:0] cas_cmp_s;
    logic       active_s;
    logic       match_s;

    inta_edge_detect u_edge (
        .clk       (clk),
        .reset     (reset),
        .inta_n    (INTA_n),
        .cas_in    (CAS_IN),
        .inta_fall (inta_fall_s),
        .inta_rise (inta_rise_s),
        .cas_cmp   (cas_cmp_s)
    );

    assign active_s = ~SNGL & ~Master_Slave;
    assign match_s  = (cas_cmp_s == Slave_ID);

    // Acknowledge sequencer with registered outputs and gap watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 8'd0;
            Selected  <= 1'b0;
            Data_oe   <= 1'b0;
            Data_out  <= 8'h00;
            Inta_done <= 1'b0;
            Ack_error <= 1'b0;
        end else begin
            Inta_done <= 1'b0;
            Ack_error <= 1'b0;
            if (!active_s) begin
                // Not a cascaded slave: abandon any sequence silently
                state_r   <= ST_IDLE;
                gap_cnt_r <= 8'd0;
                Selected  <= 1'b0;
                Data_oe   <= 1'b0;
                Data_out  <= 8'h00;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        gap_cnt_r <= 8'd0;
                        if (inta_fall_s) begin
                            state_r <= ST_ACK1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ACK1: begin
                        if (inta_rise_s) begin
                            Selected  <= match_s;
                            gap_cnt_r <= 8'd0;
                            state_r   <= ST_GAP;
                        end else begin
                            state_r <= ST_ACK1;
                        end
                    end
                    ST_GAP: begin
                        if (inta_fall_s) begin
                            state_r <= ST_ACK2;
                            Data_oe <= Selected;
                            if (Selected) begin
                                Data_out <= make_vector(Vector_base, IRQ_level, Int_pending);
                            end else begin
                                Data_out <= 8'h00;
                            end
                        end else if (gap_cnt_r == GAP_TIMEOUT) begin
                            // Second pulse never came: give up and flag it
                            state_r   <= ST_IDLE;
                            gap_cnt_r <= 8'd0;
                            Selected  <= 1'b0;
                            Ack_error <= 1'b1;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + 8'd1;
                        end
                    end
                    ST_ACK2: begin
                        if (inta_rise_s) begin
                            state_r   <= ST_IDLE;
                            Selected  <= 1'b0;
                            Data_oe   <= 1'b0;
                            Data_out  <= 8'h00;
                            Inta_done <= 1'b1;
                        end else begin
                            state_r <= ST_ACK2;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        gap_cnt_r <= 8'd0;
                        Selected  <= 1'b0;
                        Data_oe   <= 1'b0;
                        Data_out  <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cascade_slave_responder.sv
// Self-checking bench for cascade_slave_responder: directed scenarios plus
// randomized INTA/CAS traffic against a phase-counting behavioural model.
module tb_cascade_slave_responder;

    logic       clk = 1'b0;
    logic       reset, SNGL, Master_Slave, INTA_n, Int_pending;
    logic [2:0] CAS_IN, Slave_ID, IRQ_level;
    logic [4:0] Vector_base;
    logic [7:0] Data_out;
    logic       Data_oe, Selected, Inta_done, Ack_error;

`ifdef CAS_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    always #5 clk = ~clk;

    cascade_slave_responder dut (
        .clk(clk), .reset(reset), .CAS_IN(CAS_IN), .SNGL(SNGL),
        .Master_Slave(Master_Slave), .Slave_ID(Slave_ID), .INTA_n(INTA_n),
        .Vector_base(Vector_base), .IRQ_level(IRQ_level), .Int_pending(Int_pending),
        .Data_out(Data_out), .Data_oe(Data_oe), .Selected(Selected),
        .Inta_done(Inta_done), .Ack_error(Ack_error)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit cmp_en   = 1'b0;
    int done_cnt = 0, err_cnt = 0, oe_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase = number of INTA transitions seen in this sequence (0..3), wrapping to 0
    int         m_phase, m_gap;
    logic       m_prev, m_sel, m_oe, m_done, m_err;
    logic [7:0] m_data;
    logic       h_i0, h_i1;
    logic [2:0] h_c0, h_c1;

    task automatic model_step();
        logic       eff_i;
        logic [2:0] eff_c;
        logic       fall, rise, want;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (reset) begin
            m_phase = 0; m_gap = 0; m_prev = 1'b1;
            m_sel = 1'b0; m_oe = 1'b0; m_data = 8'h00;
            h_i0 = 1'b1; h_i1 = 1'b1; h_c0 = 3'd0; h_c1 = 3'd0;
        end else begin
            if (LAT == 0) begin
                eff_i = INTA_n; eff_c = CAS_IN;
            end else begin
                eff_i = h_i1; eff_c = h_c1;
                h_i1 = h_i0; h_c1 = h_c0;
                h_i0 = INTA_n; h_c0 = CAS_IN;
            end
            fall = m_prev & ~eff_i;
            rise = ~m_prev & eff_i;
            m_prev = eff_i;
            want = (m_phase % 2 == 0) ? fall : rise;
            if (SNGL || Master_Slave) begin
                m_phase = 0; m_gap = 0; m_sel = 1'b0; m_oe = 1'b0; m_data = 8'h00;
            end else if (want) begin
                m_phase = (m_phase + 1) % 4;
                if (m_phase == 2) begin
                    m_sel = (eff_c == Slave_ID);
                    m_gap = 0;
                end else if (m_phase == 3) begin
                    m_oe   = m_sel;
                    m_data = m_sel ? {Vector_base, (Int_pending ? IRQ_level : 3'd7)} : 8'h00;
                end else if (m_phase == 0) begin
                    m_sel = 1'b0; m_oe = 1'b0; m_data = 8'h00; m_done = 1'b1;
                end
            end else if (m_phase == 2) begin
                if (m_gap == 255) begin
                    m_phase = 0; m_gap = 0; m_sel = 1'b0; m_err = 1'b1;
                end else begin
                    m_gap++;
                end
            end
        end
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Pulse/enable counters, sampled just after the active edge
    initial begin : monitor_proc
        forever begin
            @(posedge clk);
            #1;
            if (Inta_done) done_cnt++;
            if (Ack_error) err_cnt++;
            if (Data_oe)   oe_cnt++;
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                n_checks++;
                if ({Selected, Data_oe, Data_out, Inta_done, Ack_error} !==
                    {m_sel, m_oe, m_data, m_done, m_err}) begin
                    n_fails++;
                    $display("FAIL cycle_compare t=%0t: got sel=%b oe=%b data=%h done=%b err=%b, expected sel=%b oe=%b data=%h done=%b err=%b",
                             $time, Selected, Data_oe, Data_out, Inta_done, Ack_error,
                             m_sel, m_oe, m_data, m_done, m_err);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two INTA pulses; reports cycles from second fall to Data_oe, the byte then, and the model byte
    task automatic run_pair(output int lat, output logic [7:0] dat, output logic [7:0] mdat);
        lat = -1; dat = 8'h00; mdat = 8'h00;
        INTA_n = 1'b0; cyc(4);
        INTA_n = 1'b1; cyc(6);
        INTA_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (lat >= 0 && Data_oe) begin
                check("data_hold", Data_out, dat);
            end
            if (Data_oe && lat < 0) begin
                lat = k; dat = Data_out; mdat = m_data;
                // Disturb latched inputs: output must not follow
                Vector_base = ~Vector_base; IRQ_level = ~IRQ_level; CAS_IN = ~CAS_IN;
            end
        end
        INTA_n = 1'b1; cyc(8);
    endtask

    initial begin : main
        int         lat, d0, e0, o0, hold;
        logic [7:0] dat, mdat;
        reset = 1'b1; SNGL = 1'b0; Master_Slave = 1'b0; INTA_n = 1'b1;
        CAS_IN = 3'd0; Slave_ID = 3'd3; Vector_base = 5'd0; IRQ_level = 3'd0; Int_pending = 1'b1;
        cyc(3);
        reset = 1'b0;
        cmp_en = 1'b1;
        check("reset_outputs", {Selected, Data_oe, Data_out, Inta_done, Ack_error}, 32'd0);

        // Basic selected acknowledge
        CAS_IN = 3'd3; Vector_base = 5'h08; IRQ_level = 3'd2; Int_pending = 1'b1;
        d0 = done_cnt;
        run_pair(lat, dat, mdat);
        check("sel_oe_latency", lat, 1 + LAT);
        check("sel_vector", dat, 8'h42);
        check("model_vector", mdat, 8'h42);
        check("sel_done_once", done_cnt - d0, 1);

        // Not addressed
        CAS_IN = 3'd5; Vector_base = 5'h08; IRQ_level = 3'd2;
        d0 = done_cnt; o0 = oe_cnt;
        run_pair(lat, dat, mdat);
        check("unsel_no_oe", oe_cnt - o0, 0);
        check("unsel_done_once", done_cnt - d0, 1);

        // Request withdrawn before vector pulse: spurious level
        CAS_IN = 3'd3; Vector_base = 5'h08; IRQ_level = 3'd2; Int_pending = 1'b0;
        run_pair(lat, dat, mdat);
        check("spurious_vector", dat, 8'h47);
        Int_pending = 1'b1;

        // Gap timeout, then a clean sequence
        CAS_IN = 3'd3; Vector_base = 5'h08; IRQ_level = 3'd2;
        e0 = err_cnt; d0 = done_cnt;
        INTA_n = 1'b0; cyc(3); INTA_n = 1'b1; cyc(262);
        check("timeout_err_once", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);
        run_pair(lat, dat, mdat);
        check("after_timeout_vec", dat, 8'h42);
        check("after_timeout_done", done_cnt - d0, 1);

        // Reset while driving the vector
        CAS_IN = 3'd3; Vector_base = 5'h08; IRQ_level = 3'd2;
        d0 = done_cnt;
        INTA_n = 1'b0; cyc(4); INTA_n = 1'b1; cyc(6); INTA_n = 1'b0;
        for (int k = 0; k < 8 && !Data_oe; k++) @(negedge clk);
        check("pre_reset_oe", Data_oe, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_oe_cleared", {Selected, Data_oe, Data_out}, 32'd0);
        INTA_n = 1'b1; cyc(1); reset = 1'b0; cyc(4);
        check("reset_no_done", done_cnt - d0, 0);

        // Leaving cascade mode during the gap
        d0 = done_cnt; e0 = err_cnt;
        INTA_n = 1'b0; cyc(4); INTA_n = 1'b1; cyc(5);
        check("gap_selected", Selected, 1'b1);
        SNGL = 1'b1;
        @(negedge clk);
        check("sngl_outputs_zero", {Selected, Data_oe, Data_out, Inta_done, Ack_error}, 32'd0);
        SNGL = 1'b0; cyc(2);
        INTA_n = 1'b0; cyc(4); INTA_n = 1'b1; cyc(270);
        check("sngl_no_done", done_cnt - d0, 0);
        check("sngl_restart_timeout", err_cnt - e0, 1);

        // Randomized traffic
        hold = 3;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 1000 == 0) Slave_ID = 3'($urandom_range(0, 7));
            if (hold == 0) begin
                INTA_n = ~INTA_n;
                if (INTA_n) begin
                    hold = ($urandom_range(0, 19) == 0) ? int'($urandom_range(250, 262))
                                                        : int'($urandom_range(1, 12));
                end else begin
                    hold = $urandom_range(1, 6);
                end
            end else begin
                hold--;
            end
            CAS_IN       = ($urandom_range(0, 1) == 1) ? Slave_ID : 3'($urandom);
            Vector_base  = 5'($urandom);
            IRQ_level    = 3'($urandom);
            Int_pending  = ($urandom_range(0, 3) != 0);
            SNGL         = ($urandom_range(0, 299) == 0);
            Master_Slave = ($urandom_range(0, 299) == 0);
            reset        = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0; SNGL = 1'b0; Master_Slave = 1'b0; INTA_n = 1'b1;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
